// File: rtl/imu_seq_pkg.sv
// Shared definitions for the IMU sample sequencer: FSM states, channel indices
// and default widths.
package imu_seq_pkg;

  localparam int NUM_CH   = 6;
  localparam int CH_W_DEF = 18;

  // Channel read order on RdAddr.
  localparam logic [2:0] CH_AX = 3'd0;
  localparam logic [2:0] CH_AY = 3'd1;
  localparam logic [2:0] CH_AZ = 3'd2;
  localparam logic [2:0] CH_GX = 3'd3;
  localparam logic [2:0] CH_GY = 3'd4;
  localparam logic [2:0] CH_GZ = 3'd5;

  // State encodings are kept as plain constants so that older blocks can share them.
  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_REQ       = 3'd1;
  localparam logic [2:0] S_CAPTURE   = 3'd2;
  localparam logic [2:0] S_COMMIT    = 3'd3;
  localparam logic [2:0] S_WAIT_CALC = 3'd4;

  typedef enum logic [2:0] {
    IDLE      = S_IDLE,
    REQ       = S_REQ,
    CAPTURE   = S_CAPTURE,
    COMMIT    = S_COMMIT,
    WAIT_CALC = S_WAIT_CALC
  } state_e;

endpackage

// File: rtl/imu_sample_sequencer_if.sv
// IMU channel read port: RdReq and RdAddr are held stable until RdAck.
// RdData is valid in the same cycle as RdAck.
interface imu_sample_sequencer_if
  import imu_seq_pkg::*;
#(
  parameter int CH_W = CH_W_DEF
);
  logic            RdReq;
  logic [2:0]      RdAddr;
  logic            RdAck;
  logic [CH_W-1:0] RdData;

  modport master (output RdReq, RdAddr, input RdAck, RdData);
  modport slave  (input RdReq, RdAddr, output RdAck, RdData);
endinterface

// File: rtl/imu_rate_tick.sv
// Sample-rate divider. The counter runs 0..SAMPLE_DIV-1 while enable is high and
// tick is asserted on the wrap cycle. While enable is low the counter is held at 0.
module imu_rate_tick #(
  parameter int SAMPLE_DIV = 50000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic enable,
  output logic tick
);
  localparam int              CW   = $clog2(SAMPLE_DIV);
  localparam logic [CW-1:0]   LAST = CW'(SAMPLE_DIV - 1);

  logic [CW-1:0] cnt_q;

  // NOTE: state registers use non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (!enable || cnt_q == LAST) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + CW'(1);
    end
  end

  assign tick = enable && (cnt_q == LAST);

endmodule

// File: rtl/imu_sample_sequencer.sv
// Reads six IMU channels on every sample tick, commits them as one frame and
// hands the frame to the calculator. Define IMU_SEQ_AVG_EN to average each new
// frame with the previously committed one.
module imu_sample_sequencer
  import imu_seq_pkg::*;
#(
  parameter int SAMPLE_DIV = 50000,
  parameter int CH_W       = CH_W_DEF,
  parameter int RD_TIMEOUT = 255
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   Enable,
  imu_sample_sequencer_if.master rd,
  output logic [CH_W-1:0]        AccelX,
  output logic [CH_W-1:0]        AccelY,
  output logic [CH_W-1:0]        AccelZ,
  output logic [CH_W-1:0]        GyroX,
  output logic [CH_W-1:0]        GyroY,
  output logic [CH_W-1:0]        GyroZ,
  output logic                   FrameValid,
  output logic                   CalcStart,
  input  logic                   CalcDone,
  output logic                   Busy,
  output logic                   Overrun,
  output logic                   TimeoutErr,
  input  logic                   ClearErr
);
  localparam int            WW        = $clog2(RD_TIMEOUT + 1);
  localparam logic [WW-1:0] WAIT_LAST = WW'(RD_TIMEOUT - 1);

  logic            tick;
  logic [2:0]      state_q;
  logic [2:0]      idx_q;
  logic [WW-1:0]   wait_q;
  logic            frame_q;
  logic [CH_W-1:0] shadow_q [NUM_CH];
  logic [CH_W-1:0] out_q    [NUM_CH];

  imu_rate_tick #(.SAMPLE_DIV(SAMPLE_DIV)) u_tick (
    .clk    (clk),
    .rst_n  (rst_n),
    .enable (Enable),
    .tick   (tick)
  );

  wire ack_hit     = (state_q == S_REQ) && rd.RdAck;
  wire timeout_hit = (state_q == S_REQ) && !rd.RdAck && (wait_q == WAIT_LAST);
  wire overrun_hit = tick && (state_q != S_IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      wait_q  <= '0;
      frame_q <= 1'b0;
    end else begin
      frame_q <= 1'b0;
      case (state_q)
        S_IDLE: if (tick) begin
          state_q <= S_REQ;
          idx_q   <= '0;
          wait_q  <= '0;
        end
        S_REQ: begin
          if (ack_hit)          state_q <= S_CAPTURE;
          else if (timeout_hit) state_q <= S_IDLE;
          else                  wait_q  <= wait_q + WW'(1);
        end
        S_CAPTURE: begin
          if (idx_q == CH_GZ) begin
            state_q <= S_COMMIT;
          end else begin
            idx_q   <= idx_q + 3'd1;
            wait_q  <= '0;
            state_q <= S_REQ;
          end
        end
        S_COMMIT: begin
          frame_q <= 1'b1;
          state_q <= S_WAIT_CALC;
        end
        S_WAIT_CALC: if (CalcDone) state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // NOTE: the shadow array is reset explicitly; a discarded partial frame must never leak out.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int c = 0; c < NUM_CH; c++) shadow_q[c] <= '0;
    end else if (ack_hit) begin
      shadow_q[idx_q] <= rd.RdData;
    end
  end

`ifdef IMU_SEQ_AVG_EN
  logic first_q;

  // Floor average: the CH_W+1-bit signed sum shifted right by one.
  function automatic logic [CH_W-1:0] avg2(input logic [CH_W-1:0] a, input logic [CH_W-1:0] b);
    logic signed [CH_W:0] sum;
    sum = $signed({a[CH_W-1], a}) + $signed({b[CH_W-1], b});
    return sum[CH_W:1];
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      first_q <= 1'b1;
      for (int c = 0; c < NUM_CH; c++) out_q[c] <= '0;
    end else if (state_q == S_COMMIT) begin
      first_q <= 1'b0;
      for (int c = 0; c < NUM_CH; c++)
        out_q[c] <= first_q ? shadow_q[c] : avg2(shadow_q[c], out_q[c]);
    end
  end
`else
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int c = 0; c < NUM_CH; c++) out_q[c] <= '0;
    end else if (state_q == S_COMMIT) begin
      for (int c = 0; c < NUM_CH; c++) out_q[c] <= shadow_q[c];
    end
  end
`endif

  // A new error wins over ClearErr in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      Overrun    <= 1'b0;
      TimeoutErr <= 1'b0;
    end else begin
      if (overrun_hit)   Overrun <= 1'b1;
      else if (ClearErr) Overrun <= 1'b0;
      if (timeout_hit)   TimeoutErr <= 1'b1;
      else if (ClearErr) TimeoutErr <= 1'b0;
    end
  end

  assign rd.RdReq   = (state_q == S_REQ);
  assign rd.RdAddr  = idx_q;
  assign FrameValid = frame_q;
  assign CalcStart  = frame_q;
  assign Busy       = (state_q != S_IDLE);

  assign AccelX = out_q[CH_AX];
  assign AccelY = out_q[CH_AY];
  assign AccelZ = out_q[CH_AZ];
  assign GyroX  = out_q[CH_GX];
  assign GyroY  = out_q[CH_GY];
  assign GyroZ  = out_q[CH_GZ];

endmodule

// File: tb/tb_imu_sample_sequencer.sv
// Self-checking bench for imu_sample_sequencer: an IMU responder with random ack
// delays feeds a frame-level reference model; IMU_SEQ_AVG_EN selects the averaging model.
module tb_imu_sample_sequencer;
  localparam int CH_W       = 18;
  localparam int SAMPLE_DIV = 16;
  localparam int RD_TIMEOUT = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic enable = 1'b0;
  logic calc_done = 1'b0;
  logic clear_err = 1'b0;
  logic [CH_W-1:0] accel_x, accel_y, accel_z, gyro_x, gyro_y, gyro_z;
  logic frame_valid, calc_start, busy, overrun, timeout_err;

  imu_sample_sequencer_if #(.CH_W(CH_W)) rd_if ();

  imu_sample_sequencer #(
    .SAMPLE_DIV (SAMPLE_DIV),
    .CH_W       (CH_W),
    .RD_TIMEOUT (RD_TIMEOUT)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .Enable     (enable),
    .rd         (rd_if),
    .AccelX     (accel_x),
    .AccelY     (accel_y),
    .AccelZ     (accel_z),
    .GyroX      (gyro_x),
    .GyroY      (gyro_y),
    .GyroZ      (gyro_z),
    .FrameValid (frame_valid),
    .CalcStart  (calc_start),
    .CalcDone   (calc_done),
    .Busy       (busy),
    .Overrun    (overrun),
    .TimeoutErr (timeout_err),
    .ClearErr   (clear_err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model and responder state.
  logic [CH_W-1:0] cur     [6];
  logic [CH_W-1:0] exp_out [6];
  bit  first_frame   = 1'b1;
  int  data_mode     = 0;
  int  ack_delay_max = 0;
  int  cur_delay     = 0;
  int  wait_cnt      = 0;
  int  no_ack_ch     = -1;
  int  next_addr     = 0;
  int  frame_acks    = 0;
  int  fv_count      = 0;
  int  req_cycles    = 0;
  int  cyc           = 0;
  int  first_req_cyc = -1;
  int  last_fv_cyc   = -1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [CH_W-1:0] dut_out(input int c);
    case (c)
      0: return accel_x;
      1: return accel_y;
      2: return accel_z;
      3: return gyro_x;
      4: return gyro_y;
      default: return gyro_z;
    endcase
  endfunction

  function automatic logic [CH_W-1:0] data_for(input int a);
    case (data_mode)
      0: return CH_W'(a * 1000);
      1: return {CH_W{1'b1}};
      2: return CH_W'(2);
      default: return CH_W'($urandom());
    endcase
  endfunction

  task automatic handle_frame();
    int n;
`ifdef IMU_SEQ_AVG_EN
    int p, s;
`endif
    check("frame_acks", frame_acks, 6);
    check("calc_start", calc_start, 1);
    for (int c = 0; c < 6; c++) begin
      n = $signed(cur[c]);
`ifdef IMU_SEQ_AVG_EN
      p = $signed(exp_out[c]);
      if (!first_frame) begin
        s = p + n;
        n = (s >= 0) ? s / 2 : (s - 1) / 2;
      end
`endif
      exp_out[c] = n[CH_W-1:0];
      check($sformatf("out_ch%0d", c), dut_out(c), exp_out[c]);
    end
    first_frame = 1'b0;
    frame_acks  = 0;
    fv_count++;
    last_fv_cyc = cyc;
  endtask

  // One clock: observe outputs just after the edge, then play the IMU side.
  task automatic step();
    logic [CH_W-1:0] d;
    @(posedge clk);
    #1;
    cyc++;
    if (frame_valid) handle_frame();
    if (rd_if.RdReq) begin
      req_cycles++;
      if (first_req_cyc < 0) first_req_cyc = cyc;
      if (int'(rd_if.RdAddr) != no_ack_ch && wait_cnt >= cur_delay) begin
        check("rd_addr", rd_if.RdAddr, next_addr);
        d = data_for(int'(rd_if.RdAddr));
        if (rd_if.RdAddr < 3'd6) cur[rd_if.RdAddr] = d;
        rd_if.RdAck  = 1'b1;
        rd_if.RdData = d;
        next_addr    = (next_addr + 1) % 6;
        frame_acks++;
        wait_cnt  = 0;
        cur_delay = $urandom_range(ack_delay_max, 0);
      end else begin
        rd_if.RdAck = 1'b0;
        wait_cnt++;
      end
    end else begin
      rd_if.RdAck = 1'b0;
    end
  endtask

  task automatic wait_frames(input int n, input int budget);
    int target;
    target = fv_count + n;
    while (fv_count < target && budget > 0) begin
      step();
      budget--;
    end
    check("frames_seen", fv_count, target);
  endtask

  task automatic wait_req_addr(input int a, input int budget);
    while (!(rd_if.RdReq && int'(rd_if.RdAddr) == a) && budget > 0) begin
      step();
      budget--;
    end
    check($sformatf("reach_addr%0d", a), rd_if.RdReq && int'(rd_if.RdAddr) == a, 1);
  endtask

  task automatic reset_model();
    for (int c = 0; c < 6; c++) exp_out[c] = '0;
    first_frame = 1'b1;
    next_addr   = 0;
    frame_acks  = 0;
    wait_cnt    = 0;
    cur_delay   = 0;
  endtask

  task automatic check_all_zero(input string tag);
    for (int c = 0; c < 6; c++) check($sformatf("%s_ch%0d", tag, c), dut_out(c), 0);
    check({tag, "_rdreq"}, rd_if.RdReq, 0);
    check({tag, "_fv"}, frame_valid, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_overrun"}, overrun, 0);
    check({tag, "_timeout"}, timeout_err, 0);
  endtask

  initial begin
    int c0, fv0, rq0, n;
    rd_if.RdAck  = 1'b0;
    rd_if.RdData = '0;
    for (int c = 0; c < 6; c++) cur[c] = '0;
    reset_model();
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset");
    rst_n = 1'b1;

    // 1: zero-wait acks, data idx*1000, latency from enable.
    calc_done = 1'b1;
    step();
    c0 = cyc;
    enable = 1'b1;
    wait_frames(1, 100);
    check("first_req_lat", first_req_cyc - c0, SAMPLE_DIV);
    check("frame_lat", last_fv_cyc - c0, SAMPLE_DIV - 1 + 14);
    check("t1_ax", accel_x, 0);
    check("t1_gz", gyro_z, 5000);
    enable = 1'b0;
    repeat (3) step();

    // 2: all-ones data, then 2 on top of it.
    data_mode = 1;
    enable = 1'b1;
    wait_frames(2, 200);
    check("t2_neg1", accel_z, 18'h3FFFF);
    data_mode = 2;
    wait_frames(1, 100);
`ifdef IMU_SEQ_AVG_EN
    check("t2_avg", gyro_y, 0);
`else
    check("t2_raw", gyro_y, 2);
`endif
    enable = 1'b0;
    repeat (3) step();

    // 3: calculator stalls across two ticks.
    data_mode = 3;
    calc_done = 1'b0;
    enable = 1'b1;
    wait_frames(1, 100);
    rq0 = req_cycles;
    repeat (2 * SAMPLE_DIV + 4) step();
    check("t3_no_req", req_cycles, rq0);
    check("t3_overrun", overrun, 1);
    check("t3_busy", busy, 1);
    enable = 1'b0;
    clear_err = 1'b1;
    calc_done = 1'b1;
    step();
    clear_err = 1'b0;
    step();
    check("t3_cleared", overrun, 0);
    check("t3_idle", busy, 0);
    enable = 1'b1;
    wait_frames(1, 100);
    enable = 1'b0;
    repeat (3) step();

    // 4: channel 3 never acknowledged.
    no_ack_ch = 3;
    enable = 1'b1;
    wait_req_addr(3, 100);
    enable = 1'b0;
    n = 0;
    while (rd_if.RdReq && n < 50) begin
      n++;
      step();
    end
    check("t4_req_len", n, RD_TIMEOUT);
    check("t4_timeout", timeout_err, 1);
    check("t4_idle", busy, 0);
    for (int c = 0; c < 6; c++) check($sformatf("t4_keep_ch%0d", c), dut_out(c), exp_out[c]);
    no_ack_ch = -1;
    next_addr = 0;
    frame_acks = 0;
    wait_cnt = 0;
    clear_err = 1'b1;
    step();
    clear_err = 1'b0;
    step();
    check("t4_cleared", timeout_err, 0);

    // 5: asynchronous reset while waiting on channel 2.
    no_ack_ch = 2;
    enable = 1'b1;
    wait_req_addr(2, 100);
    rd_if.RdAck = 1'b0;
    rst_n = 1'b0;
    #1;
    check_all_zero("t5");
    reset_model();
    no_ack_ch = -1;
    enable = 1'b0;
    step();
    rst_n = 1'b1;
    fv0 = fv_count;
    repeat (30) step();
    check("t5_no_fv", fv_count, fv0);

    // 6: Enable dropped mid-frame.
    data_mode = 0;
    enable = 1'b1;
    wait_req_addr(2, 100);
    enable = 1'b0;
    wait_frames(1, 60);
    rq0 = req_cycles;
    repeat (3 * SAMPLE_DIV) step();
    check("t6_no_req", req_cycles, rq0);

    // Random data and ack delays.
    data_mode = 3;
    ack_delay_max = 2;
    enable = 1'b1;
    wait_frames(6, 3000);
    enable = 1'b0;
    repeat (60) step();
    check("final_idle", busy, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
